ifu_fetch_controller: RTL and testbench

//   Fetch-side consumer of the commit stage's valid/ready handshake. Accepts "commit done + next PC",

---
 rtl/ifu_fetch_controller.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_controller.sv
// ifu_fetch_controller
//   Fetch stage of a single-issue core. Accepts the next PC from commit
//   (valid_pre/ready_pre), reads one instruction word over AXI4-Lite (AR/R),
//   then presents {pc, inst, fetch_err} to decode (valid_post/ready_post).
//   Only one instruction is ever in flight. The first fetch after reset goes
//   to RESET_PC without waiting for a commit.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   valid_pre_i/ready_pre_o commit -> fetch handshake, npc_i = next PC
//   arvalid_o/arready_i     AXI-Lite read address, araddr_o = current PC
//   rvalid_i/rready_o       AXI-Lite read data, rdata_i/rresp_i
//   valid_post_o/ready_post_i fetch -> decode handshake
//   pc_o, inst_o, fetch_err_o payload toward decode
//
// Handshake outputs are decoded from the state register, so they fall
// immediately when reset is asserted.
module ifu_fetch_controller #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_pre_i,
  output logic            ready_pre_o,
  input  logic [XLEN-1:0] npc_i,
  output logic            arvalid_o,
  output logic [XLEN-1:0] araddr_o,
  input  logic            arready_i,
  input  logic            rvalid_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rresp_i,
  output logic            rready_o,
  output logic            valid_post_o,
  input  logic            ready_post_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            fetch_err_o
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;
  logic            err_r;
  logic            misaligned_s;
  logic            rd_err_s;

  assign misaligned_s = (npc_i[1:0] != 2'b00);
  assign rd_err_s     = (rresp_i != 2'b00);

  // Next-state and handshake decode
  always_comb begin
    state_nxt_s  = state_r;
    ready_pre_o  = 1'b0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    valid_post_o = 1'b0;
    case (state_r)
      BOOT: begin
        state_nxt_s = ADDR;
      end
      IDLE: begin
        ready_pre_o = 1'b1;
        if (valid_pre_i) begin
          // A misaligned PC never reaches the bus; report it straight away.
          if (misaligned_s) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ADDR;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = DATA;
        end
      end
      HOLD: begin
        valid_post_o = 1'b1;
        if (ready_post_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State, PC and fetched-instruction registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      inst_r  <= {XLEN{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (valid_pre_i) begin
            pc_r <= npc_i;
            if (misaligned_s) begin
              inst_r <= {XLEN{1'b0}};
              err_r  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rvalid_i) begin
            // Errored reads deliver a zero instruction word.
            err_r  <= rd_err_s;
            inst_r <= rd_err_s ? {XLEN{1'b0}} : rdata_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign araddr_o    = pc_r;
  assign pc_o        = pc_r;
  assign inst_o      = inst_r;
  assign fetch_err_o = err_r;

endmodule

// File: tb/tb_ifu_fetch_controller.sv
// Self-checking bench for ifu_fetch_controller: directed scenarios followed
// by randomized transactions checked against a transaction-level model.
module tb_ifu_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_pre_i = 1'b0;
  logic        ready_pre_o;
  logic [31:0] npc_i = 32'h0;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic        arready_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rready_o;
  logic        valid_post_o;
  logic        ready_post_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fetch_err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int ar_hs    = 0;

  ifu_fetch_controller #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o), .npc_i(npc_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; count the AR handshake that completes on this edge.
  task automatic tick();
    if (arvalid_o && arready_i && reset) ar_hs++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] npc, exp_inst, hold_pc, hold_inst;
    logic        exp_err, got, mis;
    int          ar_before, lat;

    // ---- 1: reset, then first fetch from RESET_PC
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready_pre", ready_pre_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_valid_post", valid_post_o, 0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_inst", inst_o, 0);
    chk("rst_err", fetch_err_o, 0);
    arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h0000_0413; rresp_i = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    chk("boot_arvalid", arvalid_o, 0);
    tick();
    chk("t1_arvalid_c1", arvalid_o, 1);
    chk("t1_araddr_c1", araddr_o, RST_PC);
    tick();
    chk("t1_rready_c2", rready_o, 1);
    chk("t1_arvalid_c2", arvalid_o, 0);
    tick();
    chk("t1_valid_post_c3", valid_post_o, 1);
    chk("t1_pc", pc_o, RST_PC);
    chk("t1_inst", inst_o, 32'h0000_0413);
    chk("t1_err", fetch_err_o, 0);
    chk("t1_ar_count", ar_hs, 1);

    // ---- 2: decode stalls four cycles; commit is held off
    valid_pre_i = 1'b1; npc_i = 32'h1234_5678; rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_valid_post", valid_post_o, 1);
      chk("t2_pc", pc_o, RST_PC);
      chk("t2_inst", inst_o, 32'h0000_0413);
      chk("t2_ready_pre", ready_pre_o, 0);
    end
    valid_pre_i = 1'b0; ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0;
    chk("t2_idle_ready_pre", ready_pre_o, 1);
    chk("t2_idle_valid_post", valid_post_o, 0);
    chk("t2_idle_pc", pc_o, RST_PC);

    // ---- 3: AR stalled three cycles; stray rvalid in ADDR is ignored
    ar_before = ar_hs;
    valid_pre_i = 1'b1; npc_i = 32'h8000_0010; arready_i = 1'b0; rvalid_i = 1'b1;
    rdata_i = 32'hBAD0_BAD0;
    tick();
    valid_pre_i = 1'b0; npc_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_arvalid", arvalid_o, 1);
      chk("t3_araddr", araddr_o, 32'h8000_0010);
      tick();
    end
    chk("t3_arvalid_last", arvalid_o, 1);
    arready_i = 1'b1; rvalid_i = 1'b0;
    tick();
    arready_i = 1'b0;
    chk("t3_arvalid_dropped", arvalid_o, 0);
    chk("t3_rready", rready_o, 1);
    tick();
    chk("t3_rready_wait", rready_o, 1);
    rvalid_i = 1'b1; rdata_i = 32'h0010_0093;
    tick();
    rvalid_i = 1'b0;
    chk("t3_ar_count", ar_hs - ar_before, 1);
    chk("t3_valid_post", valid_post_o, 1);
    chk("t3_pc", pc_o, 32'h8000_0010);
    chk("t3_inst", inst_o, 32'h0010_0093);
    chk("t3_err", fetch_err_o, 0);
    ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0;

    // ---- 4: SLVERR response
    valid_pre_i = 1'b1; npc_i = 32'h8000_0020; arready_i = 1'b1; rvalid_i = 1'b1;
    rdata_i = 32'hDEAD_BEEF; rresp_i = 2'b10;
    tick();
    valid_pre_i = 1'b0;
    tick();
    tick();
    chk("t4_valid_post", valid_post_o, 1);
    chk("t4_err", fetch_err_o, 1);
    chk("t4_inst", inst_o, 0);
    chk("t4_pc", pc_o, 32'h8000_0020);
    rresp_i = 2'b00; ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0;

    // ---- 5: misaligned PC bypasses the bus
    ar_before = ar_hs;
    valid_pre_i = 1'b1; npc_i = 32'h8000_0006;
    tick();
    valid_pre_i = 1'b0;
    chk("t5_arvalid", arvalid_o, 0);
    chk("t5_valid_post", valid_post_o, 1);
    chk("t5_err", fetch_err_o, 1);
    chk("t5_inst", inst_o, 0);
    chk("t5_pc", pc_o, 32'h8000_0006);
    chk("t5_ar_count", ar_hs - ar_before, 0);
    ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0;

    // ---- 6: reset during DATA
    valid_pre_i = 1'b1; npc_i = 32'h8000_0040; arready_i = 1'b1; rvalid_i = 1'b0;
    tick();
    valid_pre_i = 1'b0;
    tick();
    chk("t6_rready_before", rready_o, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rready_async", rready_o, 0);
    chk("t6_arvalid_async", arvalid_o, 0);
    chk("t6_valid_post_async", valid_post_o, 0);
    chk("t6_ready_pre_async", ready_pre_o, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("t6_pc_reset", araddr_o, RST_PC);
    tick();
    chk("t6_restart_arvalid", arvalid_o, 1);
    chk("t6_restart_araddr", araddr_o, RST_PC);
    rvalid_i = 1'b1; rdata_i = 32'h0000_0013;
    tick();
    tick();
    chk("t6_restart_inst", inst_o, 32'h0000_0013);
    ready_post_i = 1'b1;
    tick();
    ready_post_i = 1'b0; rvalid_i = 1'b0; arready_i = 1'b0;

    // ---- Randomized transactions against a transaction-level model
    for (int t = 0; t < 40; t++) begin
      npc = RST_PC | ($urandom & 32'h000F_FFFC);
      if ($urandom_range(0, 3) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      mis      = (npc[1:0] != 2'b00);
      exp_err  = mis;
      exp_inst = 32'h0;
      chk("rnd_ready_pre", ready_pre_o, 1);
      ar_before = ar_hs;
      valid_pre_i = 1'b1; npc_i = npc;
      tick();
      valid_pre_i = 1'b0; npc_i = $urandom;
      got = 1'b0; lat = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        if (valid_post_o) begin
          got = 1'b1;
          lat = c;
        end else begin
          if (arvalid_o) chk("rnd_araddr", araddr_o, npc);
          arready_i = 1'($urandom_range(0, 1));
          rvalid_i  = 1'($urandom_range(0, 1));
          rdata_i   = $urandom;
          rresp_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          if (rvalid_i && rready_o) begin
            exp_err  = (rresp_i != 2'b00);
            exp_inst = exp_err ? 32'h0 : rdata_i;
          end
          tick();
        end
      end
      arready_i = 1'b0; rvalid_i = 1'b0;
      chk("rnd_valid_post_seen", got, 1);
      if (mis) chk("rnd_mis_latency", lat, 0);
      chk("rnd_pc", pc_o, npc);
      chk("rnd_inst", inst_o, exp_inst);
      chk("rnd_err", fetch_err_o, exp_err);
      chk("rnd_ar_count", ar_hs - ar_before, mis ? 0 : 1);
      hold_pc = pc_o; hold_inst = inst_o;
      repeat ($urandom_range(0, 2)) begin
        rvalid_i = 1'b1; rdata_i = $urandom; valid_pre_i = 1'b1;
        tick();
        chk("rnd_hold_valid", valid_post_o, 1);
        chk("rnd_hold_pc", pc_o, hold_pc);
        chk("rnd_hold_inst", inst_o, hold_inst);
      end
      rvalid_i = 1'b0; valid_pre_i = 1'b0; ready_post_i = 1'b1;
      tick();
      ready_post_i = 1'b0;
      chk("rnd_post_drop", valid_post_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
